// File: rtl/sift_pkg.sv
// Shared pixel and frame constants for the SIFT front-end pipeline, plus the
// small helpers the 2x2 decimator uses to decode block position and round.
package sift_pkg;

    // Pixel and frame geometry (defaults for the 800x600 sensor path).
    localparam int PIX_W = 8;
    localparam int IN_W  = 800;
    localparam int IN_H  = 600;

    // One output pixel per 2x2 input block; the Gaussian stage counts this.
    localparam int OUT_PIX_PER_FRAME = IN_W * IN_H / 4;

    // Widths of the partial sums: two pixels, then all four pixels.
    localparam int SUM2_W = PIX_W + 1;
    localparam int SUM4_W = PIX_W + 2;

    // Position of an input pixel inside its 2x2 block.
    typedef enum logic [1:0] {
        PH_TOP_LEFT  = 2'b00,
        PH_TOP_RIGHT = 2'b01,
        PH_BOT_LEFT  = 2'b10,
        PH_BOT_RIGHT = 2'b11
    } blk_phase_e;

    // Block phase from row/column parity.
    function automatic blk_phase_e blk_phase(input logic row_odd, input logic col_odd);
        return blk_phase_e'({row_odd, col_odd});
    endfunction

    // Divide a four-pixel sum by 4, rounding halves up. The maximum sum is
    // 1020, so the biased value still fits SUM4_W bits and the quotient fits
    // a pixel without saturation.
    function automatic logic [PIX_W-1:0] round_div4(input logic [SUM4_W-1:0] sum);
        logic [SUM4_W-1:0] biased;
        biased = sum + SUM4_W'(2);
        return biased[SUM4_W-1:2];
    endfunction

endpackage

// File: rtl/line_buf_sdp.sv
// Simple dual-port line buffer: one write port, one registered read port.
// Holds the horizontal pair sums of the even row until the odd row below
// consumes them.
module line_buf_sdp
    import sift_pkg::*;
#(
    parameter int DEPTH = IN_W / 2,
    parameter int AW    = 9,
    parameter int DW    = SUM2_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rd_data;

    // Storage write port.
    // NOTE: the array has no reset; every entry is rewritten on an even row
    // before the odd row reads it, and a reset would prevent RAM inference.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read port; only this output register is reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/down_sample_2x.sv
// 2x2 box-filter decimator. Pulls an IN_W x IN_H raster from the image FIFO,
// averages each non-overlapping 2x2 block with round-half-up, and offers one
// pixel per block through a two-entry output queue (output register + skid).
module down_sample_2x
    import sift_pkg::*;
#(
    parameter int IN_W  = sift_pkg::IN_W,
    parameter int IN_H  = sift_pkg::IN_H,
    parameter int LB_AW = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic             fifo_valid,
    input  logic [PIX_W-1:0] fifo_dout,
    output logic             valid,
    output logic [PIX_W-1:0] dout,
    input  logic             rd_en,
    output logic             frame_done
);

    localparam int COL_W = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int ROW_W = (IN_H > 1) ? $clog2(IN_H) : 1;

    // Raster position of the pixel currently on fifo_dout.
    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    // Left pixel of the current block row pair.
    logic [PIX_W-1:0]  r_hold;
    // A FIFO read was issued last cycle, so fifo_valid this cycle is ours.
    logic              r_rd_pend;
    // Output queue: r_q0 is the presented head, r_q1 the skid slot.
    logic [PIX_W-1:0]  r_q0;
    logic [PIX_W-1:0]  r_q1;
    logic [1:0]        r_cnt;

    logic              w_accept;
    blk_phase_e        w_phase;
    logic              w_col_last;
    logic              w_row_last;
    logic [LB_AW-1:0]  w_k;
    logic              w_hold_ld;
    logic              w_lb_wr;
    logic              w_lb_rd;
    logic              w_push;
    logic [SUM2_W-1:0] w_lb_wdata;
    logic [SUM2_W-1:0] w_lb_rdata;
    logic [SUM4_W-1:0] w_sum;
    logic [PIX_W-1:0]  w_push_data;
    logic              w_valid;
    logic              w_pop;
    logic              w_skid_full;

    // Read data is only taken when we asked for it; stray or pre-reset beats
    // are dropped here and never move the counters.
    assign w_accept   = fifo_valid & r_rd_pend;
    assign w_phase    = blk_phase(r_row[0], r_col[0]);
    assign w_col_last = (r_col == COL_W'(IN_W - 1));
    assign w_row_last = (r_row == ROW_W'(IN_H - 1));
    assign w_k        = LB_AW'(r_col >> 1);

    // Per-pixel action decode from the block phase.
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_hold_ld  = 1'b0;
        w_lb_wr    = 1'b0;
        w_lb_rd    = 1'b0;
        w_push     = 1'b0;
        w_lb_wdata = SUM2_W'(r_hold) + SUM2_W'(fifo_dout);
        w_sum      = SUM4_W'(w_lb_rdata) + SUM4_W'(r_hold) + SUM4_W'(fifo_dout);
        if (w_accept) begin
            case (w_phase)
                PH_TOP_LEFT:  w_hold_ld = 1'b1;
                PH_TOP_RIGHT: w_lb_wr   = 1'b1;
                PH_BOT_LEFT: begin
                    w_hold_ld = 1'b1;
                    w_lb_rd   = 1'b1;
                end
                PH_BOT_RIGHT: w_push    = 1'b1;
                default:      ;
            endcase
        end
    end

    assign w_push_data = round_div4(w_sum);

    // Raster counters, advanced only by accepted pixels.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    // Left-pixel hold register and read-in-flight tracker.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold    <= '0;
            r_rd_pend <= 1'b0;
        end else begin
            r_rd_pend <= fifo_rd_en;
            if (w_hold_ld) begin
                r_hold <= fifo_dout;
            end
        end
    end

    line_buf_sdp #(
        .DEPTH (IN_W / 2),
        .AW    (LB_AW),
        .DW    (SUM2_W)
    ) u_line_buf (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_lb_wr),
        .i_wr_addr (w_k),
        .i_wr_data (w_lb_wdata),
        .i_rd_en   (w_lb_rd),
        .i_rd_addr (w_k),
        .o_rd_data (w_lb_rdata)
    );

    assign w_valid     = (r_cnt != 2'd0);
    assign w_pop       = w_valid & rd_en;
    assign w_skid_full = (r_cnt == 2'd2);

    // Two-entry output queue; push and pop in the same cycle keep FIFO order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q0  <= '0;
            r_q1  <= '0;
            r_cnt <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_q0  <= w_push_data;
                        r_cnt <= 2'd1;
                    end else begin
                        r_q1  <= w_push_data;
                        r_cnt <= 2'd2;
                    end
                end
                2'b01: begin
                    r_q0  <= r_q1;
                    r_cnt <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd2) begin
                        r_q0 <= r_q1;
                        r_q1 <= w_push_data;
                    end else begin
                        r_q0 <= w_push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    // Read upstream only when a returning pixel can always be stored: the
    // skid is free and the head is not being held by the consumer. The reset
    // term forces the strobe low while rst is asserted.
    assign fifo_rd_en = rst & ~fifo_empty & ~w_skid_full & ~(w_valid & ~rd_en);
    assign valid      = w_valid;
    assign dout       = r_q0;
    assign frame_done = w_push & w_row_last & w_col_last;

    // The skid never overflows: pushes are at least two pixels apart.
    a_no_push_when_full : assert property (
        @(posedge clk) disable iff (!rst) !(w_push && w_skid_full)
    );

    // Upstream must only return data for reads we issued.
    a_valid_has_read : assert property (
        @(posedge clk) disable iff (!rst) fifo_valid |-> r_rd_pend
    );

endmodule

// File: tb/tb_down_sample_2x.sv
// Self-checking bench for down_sample_2x on a reduced 32x8 frame. A source
// queue models the upstream FIFO (data one cycle after the read strobe) and a
// scoreboard queue holds the golden block averages in output order.
module tb_down_sample_2x;

    localparam int W         = 32;
    localparam int H         = 8;
    localparam int AW        = 4;
    localparam int FRAME_PIX = W * H;
    localparam int OUT_PIX   = FRAME_PIX / 4;

    logic       clk        = 1'b0;
    logic       rst        = 1'b0;
    logic       fifo_empty = 1'b0;
    logic       fifo_valid = 1'b0;
    logic [7:0] fifo_dout  = 8'd0;
    logic       rd_en      = 1'b0;
    logic       fifo_rd_en;
    logic       valid;
    logic [7:0] dout;
    logic       frame_done;

    down_sample_2x #(
        .IN_W  (W),
        .IN_H  (H),
        .LB_AW (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_valid (fifo_valid),
        .fifo_dout  (fifo_dout),
        .valid      (valid),
        .dout       (dout),
        .rd_en      (rd_en),
        .frame_done (frame_done)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] src_q [$];
    logic [7:0] exp_q [$];
    logic [7:0] frm [H][W];
    int         dir_pix [4][4];
    int         dir_exp [4];
    int         pix_cnt = 0;
    int         out_cnt = 0;
    int         fd_cnt = 0;
    int         bubble_pct = 0;
    bit         rand_rd = 1'b0;
    bit         cur_last = 1'b0;
    bit         hold_prev = 1'b0;
    logic [7:0] prev_dout = 8'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Push a frame to the source queue and its block averages to the scoreboard.
    task automatic load_frame(input bit directed);
        int s;
        int e;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                src_q.push_back(frm[r][c]);
        for (int br = 0; br < H / 2; br++) begin
            for (int k = 0; k < W / 2; k++) begin
                s = int'(frm[2*br][2*k]) + int'(frm[2*br][2*k+1])
                  + int'(frm[2*br+1][2*k]) + int'(frm[2*br+1][2*k+1]);
                e = (s + 2) / 4;
                if (directed && br == 0 && k < 4) e = dir_exp[k];
                exp_q.push_back(8'(e));
            end
        end
    endtask

    task automatic fill_const(input logic [7:0] v);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                frm[r][c] = v;
    endtask

    task automatic fill_rand();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                frm[r][c] = 8'($urandom);
    endtask

    // One clock: sample/check outputs on the falling edge, drive after rising.
    task automatic cycle();
        bit take;
        @(negedge clk);
        check("frame_done", frame_done, fifo_valid && cur_last);
        if (frame_done === 1'b1) fd_cnt++;
        if (hold_prev) begin
            check("hold_valid", valid, 1);
            check("hold_dout", dout, prev_dout);
        end
        if (valid && !rd_en) check("bp_fifo_rd_en", fifo_rd_en, 0);
        if (fifo_empty) check("rd_while_empty", fifo_rd_en, 0);
        hold_prev = valid && !rd_en;
        prev_dout = dout;
        if (valid && rd_en) begin
            check("spurious_out", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("dout", dout, exp_q.pop_front());
            out_cnt++;
        end
        take = fifo_rd_en && !fifo_empty && (src_q.size() != 0);
        @(posedge clk);
        #1;
        fifo_valid = take;
        if (take) begin
            fifo_dout = src_q.pop_front();
            cur_last  = (pix_cnt % FRAME_PIX) == FRAME_PIX - 1;
            pix_cnt++;
        end else begin
            fifo_dout = 8'($urandom);
            cur_last  = 1'b0;
        end
        fifo_empty = (src_q.size() == 0) || ($urandom_range(99) < bubble_pct);
        if (rand_rd) rd_en = 1'($urandom_range(1));
    endtask

    task automatic drain(input string tag, input int budget);
        int cyc;
        cyc = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0) && cyc < budget) begin
            cycle();
            cyc++;
        end
        check({tag, "_budget"}, cyc < budget, 1);
        repeat (4) cycle();
    endtask

    task automatic clear_counts();
        out_cnt = 0;
        fd_cnt  = 0;
    endtask

    initial begin
        int start;
        int cyc;
        dir_pix = '{'{10, 20, 30, 41}, '{1, 1, 1, 0}, '{255, 255, 255, 255}, '{0, 0, 0, 1}};
        dir_exp = '{25, 1, 255, 0};

        // Reset state, with the FIFO reporting data so the strobe gating is exercised.
        #3;
        check("rst_valid", valid, 0);
        check("rst_dout", dout, 0);
        check("rst_fifo_rd_en", fifo_rd_en, 0);
        check("rst_frame_done", frame_done, 0);
        fifo_empty = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b1;
        rd_en = 1'b1;

        // Constant frame, no bubbles, consumer always ready.
        clear_counts();
        fill_const(8'd100);
        load_frame(1'b0);
        drain("const100", 2000);
        check("const100_count", out_cnt, OUT_PIX);
        check("const100_frame_done", fd_cnt, 1);

        // Rounding corner blocks in the first block row, random elsewhere.
        clear_counts();
        fill_rand();
        for (int k = 0; k < 4; k++) begin
            frm[0][2*k]   = 8'(dir_pix[k][0]);
            frm[0][2*k+1] = 8'(dir_pix[k][1]);
            frm[1][2*k]   = 8'(dir_pix[k][2]);
            frm[1][2*k+1] = 8'(dir_pix[k][3]);
        end
        load_frame(1'b1);
        drain("rounding", 2000);
        check("rounding_count", out_cnt, OUT_PIX);

        // Backpressure: consumer stalls for 50 cycles mid-frame.
        clear_counts();
        fill_rand();
        load_frame(1'b0);
        repeat (40) cycle();
        rd_en = 1'b0;
        repeat (50) cycle();
        check("bp_rd_en_low", fifo_rd_en, 0);
        check("bp_valid_high", valid, 1);
        rd_en = 1'b1;
        drain("backpressure", 2000);
        check("bp_count", out_cnt, OUT_PIX);
        check("bp_frame_done", fd_cnt, 1);

        // Two frames with random FIFO bubbles and random consumer readiness.
        clear_counts();
        bubble_pct = 50;
        rand_rd    = 1'b1;
        fill_rand();
        load_frame(1'b0);
        fill_rand();
        load_frame(1'b0);
        drain("random", 8000);
        check("random_count", out_cnt, 2 * OUT_PIX);
        check("random_frame_done", fd_cnt, 2);
        bubble_pct = 0;
        rand_rd    = 1'b0;
        rd_en      = 1'b1;

        // Reset in the middle of an odd row past the frame midpoint.
        clear_counts();
        fill_rand();
        load_frame(1'b0);
        start = pix_cnt;
        cyc   = 0;
        while (!((pix_cnt - start) >= ((H / 2 + 1) * W + W / 2) && valid === 1'b1) && cyc < 2000) begin
            cycle();
            cyc++;
        end
        check("rst_seek_budget", cyc < 2000, 1);
        check("pre_rst_fifo_rd_en", fifo_rd_en, 1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_valid", valid, 0);
        check("async_rst_fifo_rd_en", fifo_rd_en, 0);
        check("async_rst_frame_done", frame_done, 0);
        src_q.delete();
        exp_q.delete();
        fifo_valid = 1'b0;
        fifo_empty = 1'b1;
        pix_cnt    = 0;
        cur_last   = 1'b0;
        hold_prev  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        clear_counts();
        fill_const(8'd7);
        load_frame(1'b0);
        drain("const7", 2000);
        check("const7_count", out_cnt, OUT_PIX);
        check("const7_frame_done", fd_cnt, 1);

        // Gradient: each block carries its block-column index.
        clear_counts();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                frm[r][c] = 8'((c / 2) & 8'hFF);
        load_frame(1'b0);
        drain("gradient", 2000);
        check("gradient_count", out_cnt, OUT_PIX);
        check("gradient_frame_done", fd_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/down_sample_2x.md
Name: down_sample_2x

Overview:
- 2x2 box-filter decimator that sits directly upstream of the Gaussian stage.
- Reads an 8-bit raster frame (IN_W x IN_H, default 800x600) from the image-buffer FIFO.
- Averages each non-overlapping 2x2 block with rounding and presents one 8-bit pixel per block: 400x300 = 120000 pixels per frame, which is the frame length the Gaussian stage counts.
- Downstream handshake: the consumer asserts rd_en while valid is high.

Parameters:
- IN_W, 800, input pixels per row (even).
- IN_H, 600, input rows per frame (even).
- LB_AW, 9, line-buffer address width; must satisfy 2^LB_AW >= IN_W/2.

Ports:
- clk  in  1  single clock
- rst  in  1  reset, asynchronous, active-low
- fifo_empty  in  1  upstream FIFO empty
- fifo_rd_en  out  1  upstream FIFO read strobe
- fifo_valid  in  1  upstream read data valid, one cycle after fifo_rd_en
- fifo_dout  in  8  upstream pixel
- valid  out  1  output pixel available
- dout  out  8  averaged pixel
- rd_en  in  1  consumer accepts dout this cycle when valid=1
- frame_done  out  1  one-cycle pulse when the last block of a frame is enqueued

Behaviour:
- Reset (rst=0, async):
  - valid=0, dout=0, fifo_rd_en=0, frame_done=0.
  - col=0, row=0, output queue emptied.
  - Line-buffer contents are not cleared; every entry is rewritten on an even row before it is read.
- Counters:
  - col 0..IN_W-1 advances on each fifo_valid.
  - At IN_W-1, col wraps to 0 and row increments.
  - row wraps to 0 after IN_H-1.
  - Only fifo_valid advances the counters; empty-FIFO bubbles are invisible to the output.
- Even row, col=2k: latch p into hold register.
- Even row, col=2k+1: write hold+p (9-bit) to line_buf[k].
- Odd row, col=2k: latch p, issue line_buf[k] read (1-cycle sync read, result registered).
- Odd row, col=2k+1:
  - s = line_buf[k] + hold + p (10-bit, max 1020).
  - Result = (s+2)>>2, i.e. round-half-up, range 0..255, no saturation needed.
  - Enqueue the result.
- Output queue: 2 entries (output register plus one skid).
  - valid = queue non-empty; dout = head entry.
  - Pop on valid & rd_en; dout/valid hold stable while valid & !rd_en.
- Latency: qualifying odd-row odd-col pixel at cycle t, queue empty -> valid=1 at t+1.
- Simultaneous push and pop: allowed; occupancy is unchanged and order is FIFO.
- fifo_rd_en = !fifo_empty & !skid_full & !(valid & !rd_en).
  - At most one read is in flight.
  - Outputs are >=2 input pixels apart, so the skid can never overflow.
  - An assertion checks no push occurs when the queue is full.
- frame_done: pulse in the cycle the enqueue for row=IN_H-1, col=IN_W-1 occurs. Counters then wrap and the next pixel is row 0, col 0.
- fifo_valid without a preceding fifo_rd_en: ignored (assertion flags it).
- Reset mid-frame:
  - In-flight read data is discarded.
  - The next accepted pixel is treated as row 0, col 0.

Decomposition:
- Shared package sift_pkg:
  - PIX_W=8
  - frame constants IN_W/IN_H
  - derived OUT_PIX_PER_FRAME = IN_W*IN_H/4 = 120000
- One sub-module, line_buf_sdp:
  - Simple dual-port RAM, depth IN_W/2, 9-bit width.
  - One write port, one registered read port.
  - Async active-low reset applies only to the read register.

Test Plan:
- Constant 100 frame, FIFO never empty, rd_en=1 -> exactly 120000 valid beats, all dout=100, one frame_done pulse coincident with the final enqueue.
- Rounding:
  - First block row0 {10,20}, row1 {30,41}, s=101 -> dout=25.
  - Block {1,1,1,0} -> 1.
  - Block {255,255,255,255} -> 255.
  - Block {0,0,0,1} -> 0.
- Backpressure: hold rd_en=0 for 50 cycles with FIFO non-empty -> fifo_rd_en drops within 1 cycle, dout stable, no skipped or duplicated output; full frame matches the golden model after release.
- Random fifo_empty bubbles (50%) and random rd_en (50%) over 2 frames -> output stream identical to the bubble-free golden model, frame_done exactly twice.
- Assert rst=0 mid-row 301 -> valid, fifo_rd_en, frame_done go to 0 asynchronously. After release, a fresh constant-7 frame yields 120000 outputs of 7.
- Per-block gradient frame, each block = column index & 0xFF -> dout sequence matches per-block averages; verifies line-buffer addressing and row wrap at col 799.
